// File: rtl/scoreboard_regfile.sv
// Register file with a per-register pending-write counter and same-cycle write-back bypass.
// Register 0 reads as zero and is always ready; issues and writes to it are ignored.
module scoreboard_regfile #(
    parameter int NUM_REGS    = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_READ    = 2,
    parameter int NUM_WRITE   = 1,
    parameter int MAX_PENDING = 3,
    parameter int ADDR_WIDTH  = $clog2(NUM_REGS),
    parameter int CNT_WIDTH   = $clog2(MAX_PENDING + 1)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_READ*ADDR_WIDTH-1:0]   rsAddr,
    output logic [NUM_READ*DATA_WIDTH-1:0]   rsData,
    output logic [NUM_READ-1:0]              rsReady,
    input  logic                             issueValid,
    input  logic [ADDR_WIDTH-1:0]            issueAddr,
    output logic                             issueStall,
    input  logic [NUM_WRITE-1:0]             wEnable,
    input  logic [NUM_WRITE*ADDR_WIDTH-1:0]  wAddr,
    input  logic [NUM_WRITE*DATA_WIDTH-1:0]  wData,
    input  logic                             flush
);

    localparam int HIT_WIDTH = $clog2(NUM_WRITE + 1);
    // Wide enough to hold cnt + 1 and any hit count without wrapping.
    localparam int SUM_WIDTH = ((CNT_WIDTH > HIT_WIDTH) ? CNT_WIDTH : HIT_WIDTH) + 1;

    logic [DATA_WIDTH-1:0] regs     [NUM_REGS];
    logic [CNT_WIDTH-1:0]  cnt      [NUM_REGS];
    logic [CNT_WIDTH-1:0]  next_cnt [NUM_REGS];
    logic [HIT_WIDTH-1:0]  hits     [NUM_REGS];
    logic [NUM_REGS-1:0]   inc;
    logic                  accept;
    logic [SUM_WIDTH-1:0]  sum;
    logic [SUM_WIDTH-1:0]  sub;

    logic [ADDR_WIDTH-1:0] ra;
    logic                  byp;
    logic [DATA_WIDTH-1:0] bdata;

    assign issueStall = issueValid && (issueAddr != '0) &&
                        (cnt[issueAddr] == CNT_WIDTH'(MAX_PENDING));
    assign accept     = issueValid && !issueStall && !flush;

    always_comb begin
        for (int a = 0; a < NUM_REGS; a++) begin
            hits[a] = '0;
            for (int i = 0; i < NUM_WRITE; i++) begin
                if (wEnable[i] && (wAddr[i*ADDR_WIDTH +: ADDR_WIDTH] == ADDR_WIDTH'(a)))
                    hits[a] = hits[a] + HIT_WIDTH'(1);
            end
        end
    end

    // Counter moves by +inc - hits, floored at zero; cnt[0] stays zero since inc[0] is never set.
    always_comb begin
        sum = '0;
        sub = '0;
        for (int a = 0; a < NUM_REGS; a++) begin
            inc[a]      = accept && (a != 0) && (issueAddr == ADDR_WIDTH'(a));
            sum         = SUM_WIDTH'(cnt[a]) + SUM_WIDTH'(inc[a]);
            sub         = SUM_WIDTH'(hits[a]);
            next_cnt[a] = (sum > sub) ? CNT_WIDTH'(sum - sub) : '0;
        end
    end

    always_comb begin
        rsData  = '0;
        rsReady = '0;
        ra      = '0;
        byp     = 1'b0;
        bdata   = '0;
        for (int j = 0; j < NUM_READ; j++) begin
            ra    = rsAddr[j*ADDR_WIDTH +: ADDR_WIDTH];
            byp   = 1'b0;
            bdata = '0;
            // Later ports overwrite earlier ones so the highest matching port supplies the data.
            for (int i = 0; i < NUM_WRITE; i++) begin
                if (wEnable[i] && (wAddr[i*ADDR_WIDTH +: ADDR_WIDTH] == ra)) begin
                    byp   = 1'b1;
                    bdata = wData[i*DATA_WIDTH +: DATA_WIDTH];
                end
            end
            if (ra == '0) begin
                rsData[j*DATA_WIDTH +: DATA_WIDTH] = '0;
                rsReady[j]                         = 1'b1;
            end else if (byp) begin
                rsData[j*DATA_WIDTH +: DATA_WIDTH] = bdata;
                rsReady[j] = (SUM_WIDTH'(cnt[ra]) <= SUM_WIDTH'(hits[ra]));
            end else begin
                rsData[j*DATA_WIDTH +: DATA_WIDTH] = regs[ra];
                rsReady[j]                         = (cnt[ra] == '0);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int a = 0; a < NUM_REGS; a++) begin
                regs[a] <= '0;
                cnt[a]  <= '0;
            end
        end else begin
            for (int a = 0; a < NUM_REGS; a++)
                cnt[a] <= flush ? '0 : next_cnt[a];
            for (int i = 0; i < NUM_WRITE; i++) begin
                if (wEnable[i] && (wAddr[i*ADDR_WIDTH +: ADDR_WIDTH] != '0))
                    regs[wAddr[i*ADDR_WIDTH +: ADDR_WIDTH]] <= wData[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

endmodule

// File: tb/tb_scoreboard_regfile.sv
// Randomized and directed bench for scoreboard_regfile against an array-based reference model.
module tb_scoreboard_regfile;

    localparam int NR = 32;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int MP = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic [2*AW-1:0] rsAddr;
    logic [2*DW-1:0] rsData;
    logic [1:0]      rsReady;
    logic            issueValid;
    logic [AW-1:0]   issueAddr;
    logic            issueStall;
    logic [1:0]      wEnable;
    logic [2*AW-1:0] wAddr;
    logic [2*DW-1:0] wData;
    logic            flush;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          mcnt  [NR];
    logic [31:0] mregs [NR];
    logic [31:0] obs_data0, obs_data1;
    logic        obs_rdy0, obs_rdy1, obs_stall;

    scoreboard_regfile #(
        .NUM_REGS(NR), .DATA_WIDTH(DW), .NUM_READ(2), .NUM_WRITE(2), .MAX_PENDING(MP)
    ) dut (
        .clk(clk), .rst(rst), .rsAddr(rsAddr), .rsData(rsData), .rsReady(rsReady),
        .issueValid(issueValid), .issueAddr(issueAddr), .issueStall(issueStall),
        .wEnable(wEnable), .wAddr(wAddr), .wData(wData), .flush(flush)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    function automatic int model_hits(input int a);
        int h = 0;
        for (int i = 0; i < 2; i++)
            if (wEnable[i] && int'(wAddr[i*AW +: AW]) == a) h++;
        return h;
    endfunction

    function automatic logic model_stall();
        return issueValid && issueAddr != 0 && mcnt[issueAddr] == MP;
    endfunction

    function automatic void model_reset();
        for (int a = 0; a < NR; a++) begin
            mcnt[a]  = 0;
            mregs[a] = '0;
        end
    endfunction

    task automatic compare_outputs();
        for (int j = 0; j < 2; j++) begin
            int          a;
            int          h;
            logic [31:0] ed;
            logic        er;
            a = int'(rsAddr[j*AW +: AW]);
            h = model_hits(a);
            if (a == 0) begin
                ed = 0; er = 1;
            end else if (h > 0) begin
                ed = 0;
                for (int i = 0; i < 2; i++)
                    if (wEnable[i] && int'(wAddr[i*AW +: AW]) == a) ed = wData[i*DW +: DW];
                er = (mcnt[a] <= h);
            end else begin
                ed = mregs[a]; er = (mcnt[a] == 0);
            end
            check($sformatf("rd%0d_data x%0d", j, a), rsData[j*DW +: DW], ed);
            check($sformatf("rd%0d_ready x%0d", j, a), 32'(rsReady[j]), 32'(er));
        end
        check("issue_stall", 32'(issueStall), 32'(model_stall()));
        obs_data0 = rsData[31:0];
        obs_data1 = rsData[63:32];
        obs_rdy0  = rsReady[0];
        obs_rdy1  = rsReady[1];
        obs_stall = issueStall;
    endtask

    function automatic void model_update();
        logic st;
        st = model_stall();
        for (int a = 1; a < NR; a++) begin
            int c;
            c = mcnt[a] - model_hits(a);
            if (issueValid && !st && !flush && int'(issueAddr) == a) c++;
            mcnt[a] = flush ? 0 : ((c < 0) ? 0 : c);
        end
        for (int i = 0; i < 2; i++)
            if (wEnable[i] && wAddr[i*AW +: AW] != 0) mregs[wAddr[i*AW +: AW]] = wData[i*DW +: DW];
    endfunction

    task automatic cycle(input logic iv, input int ia, input logic [1:0] we,
                         input int wa0, input logic [31:0] wd0,
                         input int wa1, input logic [31:0] wd1,
                         input logic fl, input int r0, input int r1);
        @(negedge clk);
        issueValid = iv;
        issueAddr  = AW'(ia);
        wEnable    = we;
        wAddr      = {AW'(wa1), AW'(wa0)};
        wData      = {wd1, wd0};
        flush      = fl;
        rsAddr     = {AW'(r1), AW'(r0)};
        #1 compare_outputs();
        @(posedge clk);
        model_update();
    endtask

    task automatic idle(input int r0, input int r1);
        cycle(0, 0, 2'b00, 0, 0, 0, 0, 0, r0, r1);
    endtask

    initial begin
        rst = 1'b0; issueValid = 0; issueAddr = 0; wEnable = 0; wAddr = 0; wData = 0;
        flush = 0; rsAddr = {AW'(0), AW'(5)};
        model_reset();
        #12;
        check("reset_data_x5", rsData[31:0], 32'h0);
        check("reset_data_x0", rsData[63:32], 32'h0);
        check("reset_ready", 32'(rsReady), 32'h3);
        check("reset_stall", 32'(issueStall), 32'h0);
        @(negedge clk) rst = 1'b1;

        // Scoreboard round trip on x3.
        cycle(1, 3, 2'b00, 0, 0, 0, 0, 0, 3, 0);
        idle(3, 0);
        check("rt_not_ready", 32'(obs_rdy0), 32'h0);
        idle(3, 0);
        cycle(0, 0, 2'b01, 3, 32'hDEADBEEF, 0, 0, 0, 3, 0);
        check("rt_bypass_ready", 32'(obs_rdy0), 32'h1);
        check("rt_bypass_data", obs_data0, 32'hDEADBEEF);
        idle(3, 0);
        check("rt_reg_data", obs_data0, 32'hDEADBEEF);
        check("rt_reg_ready", 32'(obs_rdy0), 32'h1);

        // Two outstanding writes to x7.
        cycle(1, 7, 2'b00, 0, 0, 0, 0, 0, 7, 0);
        cycle(1, 7, 2'b00, 0, 0, 0, 0, 0, 7, 0);
        cycle(0, 0, 2'b01, 7, 32'h11, 0, 0, 0, 7, 0);
        check("waw_first_ready", 32'(obs_rdy0), 32'h0);
        check("waw_first_data", obs_data0, 32'h11);
        cycle(0, 0, 2'b01, 7, 32'h22, 0, 0, 0, 7, 0);
        check("waw_second_ready", 32'(obs_rdy0), 32'h1);
        check("waw_second_data", obs_data0, 32'h22);

        // Saturation on x9.
        for (int k = 0; k < 4; k++) cycle(1, 9, 2'b00, 0, 0, 0, 0, 0, 9, 0);
        check("sat_stall", 32'(obs_stall), 32'h1);
        cycle(1, 9, 2'b01, 9, 32'h99, 0, 0, 0, 9, 0);
        check("sat_stall_write_cycle", 32'(obs_stall), 32'h1);
        cycle(1, 9, 2'b00, 0, 0, 0, 0, 0, 9, 0);
        check("sat_unstall", 32'(obs_stall), 32'h0);
        for (int k = 0; k < 3; k++) cycle(0, 0, 2'b01, 9, 32'h9A, 0, 0, 0, 9, 0);
        check("sat_drain_ready", 32'(obs_rdy0), 32'h1);

        // Both write ports hit x4.
        cycle(1, 4, 2'b00, 0, 0, 0, 0, 0, 4, 0);
        cycle(1, 4, 2'b00, 0, 0, 0, 0, 0, 4, 0);
        cycle(0, 0, 2'b11, 4, 32'hA, 4, 32'hB, 0, 4, 0);
        check("mw_bypass_data", obs_data0, 32'hB);
        check("mw_bypass_ready", 32'(obs_rdy0), 32'h1);
        idle(4, 0);
        check("mw_reg_data", obs_data0, 32'hB);
        check("mw_reg_ready", 32'(obs_rdy0), 32'h1);

        // Flush with simultaneous issue and write.
        cycle(1, 1, 2'b00, 0, 0, 0, 0, 0, 1, 2);
        cycle(1, 1, 2'b00, 0, 0, 0, 0, 0, 1, 2);
        cycle(1, 2, 2'b00, 0, 0, 0, 0, 0, 1, 2);
        cycle(1, 5, 2'b01, 1, 32'h55, 0, 0, 1, 1, 5);
        idle(1, 5);
        check("flush_x1_data", obs_data0, 32'h55);
        check("flush_x1_ready", 32'(obs_rdy0), 32'h1);
        check("flush_x5_ready", 32'(obs_rdy1), 32'h1);
        idle(2, 0);
        check("flush_x2_ready", 32'(obs_rdy0), 32'h1);

        // Writes to x0 are invisible.
        cycle(1, 0, 2'b11, 0, 32'hFFFF, 0, 32'h1234, 0, 0, 0);
        check("x0_bypass", obs_data0, 32'h0);
        idle(0, 0);
        check("x0_after", obs_data0, 32'h0);

        // Random traffic on a small address window to force collisions and saturation.
        for (int n = 0; n < 400; n++) begin
            int r0, r1;
            r0 = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, NR - 1)) : int'($urandom_range(0, 7));
            r1 = int'($urandom_range(0, 7));
            cycle($urandom_range(0, 1) == 1, int'($urandom_range(0, 7)),
                  2'($urandom_range(0, 3) & $urandom_range(0, 3)),
                  int'($urandom_range(0, 7)), $urandom(),
                  int'($urandom_range(0, 7)), $urandom(),
                  $urandom_range(0, 31) == 0, r0, r1);
            if (n == 200) begin
                #2;
                issueValid = 0; wEnable = 0; flush = 0;
                rst = 1'b0;
                #1;
                check("midreset_data", rsData[31:0] | rsData[63:32], 32'h0);
                check("midreset_ready", 32'(rsReady), 32'h3);
                check("midreset_stall", 32'(issueStall), 32'h0);
                model_reset();
                @(negedge clk) rst = 1'b1;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/scoreboard_regfile.md
# scoreboard_regfile

Parametrised integer register file with a built-in per-register pending-write scoreboard and same-cycle write-back bypass. It sits between the decode stage, which reads sources and issues destinations, and one or more write-back ports. It replaces the fixed 2-read/1-write file, whose readiness depended only on the immediately preceding instruction. This block tracks up to MAX_PENDING outstanding writes per register, supports any number of read and write ports, and provides a pipeline flush.

## Interface
- NUM_REGS, 32: architectural registers; register 0 is hardwired to zero.
- DATA_WIDTH, 32: register width.
- NUM_READ, 2: read ports.
- NUM_WRITE, 1: write-back ports.
- MAX_PENDING, 3: maximum outstanding writes per register.
- ADDR_WIDTH, $clog2(NUM_REGS): register address width (derived).
- CNT_WIDTH, $clog2(MAX_PENDING+1): pending-counter width (derived).

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-low.
- rsAddr  in  NUM_READ×ADDR_WIDTH  read addresses.
- rsData  out  NUM_READ×DATA_WIDTH  read data, combinational.
- rsReady  out  NUM_READ  1 when the read value is final.
- issueValid  in  1  decode issues an instruction that writes issueAddr.
- issueAddr  in  ADDR_WIDTH  destination being issued.
- issueStall  out  1  issue refused because the counter is saturated.
- wEnable  in  NUM_WRITE  write-back valid, one bit per port.
- wAddr  in  NUM_WRITE×ADDR_WIDTH  write-back destinations.
- wData  in  NUM_WRITE×DATA_WIDTH  write-back data.
- flush  in  1  synchronous: discard all pending-write tracking.

## Operation
- **State.**
  - regs[1..NUM_REGS-1]: DATA_WIDTH each.
  - cnt[1..NUM_REGS-1]: CNT_WIDTH each.
- **Reset** (rst low, asynchronous): all regs = 0, all cnt = 0.
  - Resulting outputs for every address: rsData = 0, rsReady = 1.
  - issueStall = 0.
- **Register 0.**
  - Reads return 0 with ready = 1.
  - Writes to address 0 are ignored, and so are issues to it; they never stall.
- **Write.** For each port i with wEnable[i] and wAddr[i] ≠ 0, regs[wAddr[i]] is written.
  - If several ports hit the same address in one cycle, the highest port index wins the data.
- **Write count.** wHits(a) = number of enabled ports with wAddr = a.
- **Issue accept.** inc(a) = 1 when all of the following hold, else 0:
  - issueValid = 1;
  - issueAddr = a, with a ≠ 0;
  - issueStall = 0;
  - flush = 0.
- **issueStall** = issueValid && issueAddr ≠ 0 && cnt[issueAddr] == MAX_PENDING.
  - Combinational.
  - It does not depend on same-cycle writes.
- **Counter update.** cnt[a] ← sat0(cnt[a] + inc(a) − wHits(a)).
  - The result saturates at 0; a write with no pending issue leaves cnt at 0.
  - When flush = 1, every cnt ← 0 regardless of inc or wHits.
  - Data writes in a flush cycle still update regs.
- **Read port j** (combinational), with a = rsAddr[j]:
  - **a = 0:** rsData = 0, rsReady = 1.
  - **wHits(a) > 0** (bypass): rsData = wData of the highest matching port; rsReady = (cnt[a] ≤ wHits(a)).
  - **Otherwise:** rsData = regs[a], rsReady = (cnt[a] == 0).
- **Readiness visibility.**
  - Readiness reflects cnt before this cycle's issue.
  - A source issued in cycle N shows not-ready from cycle N+1.
- **Flush visibility.** A flush in cycle N makes every register ready from N+1.

## Timing
- **Read latency:** 0 cycles, combinational from rsAddr, cnt, regs and the write ports.
- **Write → read:**
  - Same cycle via bypass.
  - From regs starting at the next cycle.
- **Issue → not-ready:** 1 cycle.
- **Write-back → ready:**
  - Same cycle when it is the last pending write, because bypass readiness counts it.
  - cnt reaches 0 at the next edge.
- **Issue and write to the same address in one cycle:** net change is +1 − wHits.
  - Example: cnt = 1 stays 1.
  - Readiness that cycle follows the bypass rule, so cnt = 1 with one hit gives ready = 1.
- **Saturation:**
  - At cnt = MAX_PENDING, issueStall asserts the same cycle and cnt is unchanged.
  - The decode stage must hold the instruction.
- **Reset mid-operation:** takes effect asynchronously. In-flight pending state is lost and all registers read 0 and ready.

## Test plan
- **Reset.** Release rst; NUM_READ = 2.
  - Read x5 and x0 → both rsData = 0, rsReady = 1; issueStall = 0.
- **Scoreboard round trip.**
  - Cycle 0: issue x3 → cycle 1 rsReady(x3) = 0.
  - Cycle 3: wEnable, x3 = 0xDEADBEEF → same cycle rsReady = 1, rsData = 0xDEADBEEF.
  - Cycle 4: regs[x3] = 0xDEADBEEF, cnt = 0.
- **WAW pending.**
  - Issue x7 twice (cnt = 2).
  - First write 0x11 → rsReady stays 0 with bypass data 0x11.
  - Second write 0x22 → ready = 1, data 0x22.
- **Saturation.** MAX_PENDING = 3, issue x9 four times in a row.
  - Fourth cycle: issueStall = 1 and cnt stays 3.
  - Write x9 once → next cycle issueStall = 0 for the same request.
- **Multi-write conflict.** NUM_WRITE = 2, both ports write x4 (0xA to port 0, 0xB to port 1) with cnt[x4] = 2.
  - Same cycle: rsData = 0xB, rsReady = 1.
  - Next cycle: cnt = 0, regs[x4] = 0xB.
- **Flush.** Pending x1 = 2, x2 = 1; assert flush with a simultaneous issue of x5 and a write of x1 = 0x55.
  - Next cycle: all ready, regs[x1] = 0x55, cnt[x5] = 0.
  - Writes to x0 never change its read value of 0.
